// File: rtl/shift_seq.sv
// Purpose: multi-cycle sll/srl/sra sequencer using one 16/4/1-position shift stage per cycle.
// Latency: done in the cycle after edge E_N (N = shamt/16 + (shamt%16)/4 + shamt%4, max 7); N+2 cycles per back-to-back op.
// Backpressure: busy stalls the pipeline while shifting; start outside IDLE is dropped, not queued; abort flushes to IDLE.
module shift_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic [4:0]  rem;
    logic [4:0]  rem_nxt;
    logic [1:0]  op_r;
    logic [1:0]  op_nxt;
    logic [4:0]  step;
    logic [31:0] shifted;

    // Greedy step selection and the single shift stage; op 11 falls through to sll.
    always_comb begin
        step = 5'd1;
        if (rem >= 5'd16) begin
            step = 5'd16;
        end else if (rem >= 5'd4) begin
            step = 5'd4;
        end
        case (op_r)
            2'b01:   shifted = acc >> step;
            2'b10:   shifted = $signed(acc) >>> step;
            default: shifted = acc << step;
        endcase
    end

    // Next-state and datapath update; abort overrides everything, including a same-cycle start.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rem_nxt   = rem;
        op_nxt    = op_r;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = data_in;
                    rem_nxt   = shamt;
                    op_nxt    = op;
                    state_nxt = (shamt == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_nxt = shifted;
                rem_nxt = rem - step;
                if (rem == step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
            acc_nxt   = acc;
            rem_nxt   = 5'd0;
            op_nxt    = op_r;
        end
    end

    // State and datapath registers; reset beats abort and start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= 32'd0;
            rem   <= 5'd0;
            op_r  <= 2'b00;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            rem   <= rem_nxt;
            op_r  <= op_nxt;
        end
    end

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign result = acc;

endmodule

// File: tb/tb_shift_seq.sv
// Purpose: self-checking bench for shift_seq with a result scoreboard and latency/busy counts.
// Latency: expects done in cycle N+1 after accept and busy for exactly N cycles.
// Backpressure: exercises ignored mid-op start, abort (incl. abort-over-start) and mid-op reset.
module tb_shift_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op_i;
    logic [31:0] data_i;
    logic [4:0]  sh_i;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] sb[$];

    shift_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op_i),
        .data_in (data_i),
        .shamt   (sh_i),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        case (o)
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return d << s;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every done pulse must correspond to a queued expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                chk("result", result, sb.pop_front());
            end
        end
    end

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] s, input int restart_at);
        int n;
        int lat;
        int bcnt;
        n = int'(s) / 16 + (int'(s) % 16) / 4 + int'(s) % 4;
        sb.push_back(model(o, d, s));
        op_i   = o;
        data_i = d;
        sh_i   = s;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        data_i = 32'hDEADBEEF;
        sh_i   = 5'd9;
        lat    = 0;
        bcnt   = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == restart_at) begin
                start  = 1'b1;
                data_i = 32'h0000_0000;
                sh_i   = 5'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
            tick();
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, n + 1);
        chk({tag, "_busy_cycles"}, bcnt, n);
        tick();
        chk({tag, "_done_single"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic saw_done;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        op_i   = 2'b00;
        data_i = 32'd0;
        sh_i   = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_result", result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_hold", {result[31:2], busy, done}, 32'd0);
        end

        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 0);
        run_op("sra20", 2'b10, 32'h8000_0000, 5'd20, 0);
        run_op("srl20", 2'b01, 32'h8000_0000, 5'd20, 0);
        run_op("sll0", 2'b00, 32'h1234_5678, 5'd0, 0);
        run_op("srl5_restart", 2'b01, 32'hFFFF_FFFF, 5'd5, 1);
        run_op("rsvd7", 2'b11, 32'h0000_000F, 5'd7, 0);

        // Abort in the 3rd SHIFT cycle of sll-by-31: acc holds 1<<20 (steps 16,4 done).
        op_i = 2'b00; data_i = 32'h0000_0001; sh_i = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_acc", result, 32'h0010_0000);
        run_op("after_abort", 2'b00, 32'h0000_0003, 5'd4, 0);

        // Abort beats a same-cycle start.
        op_i = 2'b00; data_i = 32'hAAAA_5555; sh_i = 5'd3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 32'd0);
        chk("abort_start_done", 32'(done), 32'd0);
        chk("abort_start_acc", result, 32'h0000_0030);

        // Reset in the 3rd SHIFT cycle discards the operation.
        op_i = 2'b00; data_i = 32'h0000_0001; sh_i = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_result", result, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            saw_done = saw_done | done;
            tick();
        end
        chk("midrst_no_done", 32'(saw_done), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 0);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer for the CPU's variable-amount shifts (sll/srl/sra and their -v forms). It owns a single narrow shift stage that shifts by 16, 4 or 1 positions per cycle, and sequences it until the requested amount is consumed. It sits beside the ALU in the EX stage and raises `busy` so the hazard unit stalls the pipeline for the duration. The result is held until the next accepted request.

## Interface
- No parameters; datapath fixed at 32 bits, shift amount at 5 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  request strobe; accepted only in IDLE.
- `op`  in  2  00 = sll, 01 = srl, 10 = sra, 11 = reserved (executes as sll).
- `data_in`  in  32  operand, sampled on accept.
- `shamt`  in  5  shift amount 0..31, sampled on accept.
- `abort`  in  1  synchronous flush from the pipeline (branch/exception); returns to IDLE.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  high for exactly one cycle, while in DONE.
- `result`  out  32  accumulator value; meaningful when `done` is high, held afterwards.

## Operation
- Registers: `acc[31:0]`, `rem[4:0]`, `op_r[1:0]`, and state IDLE/SHIFT/DONE.
- Step size each SHIFT cycle, chosen greedily: 16 if rem ≥ 16, else 4 if rem ≥ 4, else 1.
- Step count N = shamt/16 + (shamt mod 16)/4 + shamt mod 4; maximum N = 7 (shamt 31).
- IDLE: when `start`=1, load acc←data_in, rem←shamt, op_r←op. Next state is DONE if shamt=0, otherwise SHIFT. When `start`=0, hold.
- SHIFT: acc←acc shifted by the step; rem←rem−step. If rem−step = 0, go to DONE; otherwise stay in SHIFT.
  - sll fills with zeros from the LSB.
  - srl fills with zeros from the MSB.
  - sra fills with acc[31]. This equals the original sign because every step preserves it.
- DONE: `done`=1. Unconditionally go to IDLE on the next edge.
- `start` in SHIFT or DONE is ignored and not queued. The requester must hold or re-issue it.
- Inputs `op`, `data_in` and `shamt` are don't-care except in the cycle a start is accepted.
- `abort`=1, from any state: go to IDLE, rem←0. acc is left unchanged.
  - `abort` has priority over `start` in the same cycle: the request is not accepted.
- `result` = acc at all times. It changes only on accept and during SHIFT.
- `busy` = (state==SHIFT). `done` = (state==DONE). Both are decoded from registered state, so glitch-free.

## Timing
- Reset: state=IDLE, acc=0, rem=0, op_r=00. Therefore busy=0, done=0, result=0x00000000 from the first cycle after the reset edge.
- `reset` wins over `abort` and `start`. Reset mid-operation discards the operation with no `done` pulse.
- Accept edge E0: `start` is sampled high in IDLE.
- `done` is high in the cycle after edge E_N, where N is the step count.
  - shamt=0: `done` is high in the cycle right after E0; `busy` never asserts.
  - `busy` is high during the cycles after E0 .. E_(N−1), i.e. N cycles.
- Earliest next accept is the edge after the DONE cycle. Back-to-back requests therefore cost N+2 cycles each.
- Worst-case occupancy: 7 SHIFT cycles + 1 DONE cycle.

## Test plan
- Reset, then idle: result=0x00000000, busy=0, done=0. Hold start=0 for 5 cycles: nothing changes.
- sll 0x00000001 by 31 → steps 16,4,4,4,1,1,1 (N=7), busy for 7 cycles, done in cycle 8 after E0, result=0x80000000.
- sra 0x80000000 by 20 → N=2 (16,4), result=0xFFFFF800.
  - srl of the same operand by 20 → result=0x00000800.
- sll 0x12345678 by 0 → done in the cycle immediately after E0, busy never high, result=0x12345678.
- srl 0xFFFFFFFF by 5 with a second start pulse raised mid-SHIFT → second request ignored, result=0x07FFFFFF, single done pulse.
- sll by 31 with abort asserted in the 3rd SHIFT cycle → IDLE next edge, no done pulse. A start with abort=0 on the following cycle is accepted normally.
- sll by 31 with reset asserted in the 3rd SHIFT cycle → all registers cleared, no done pulse, result=0x00000000.
